fadd_pipe: RTL and testbench
============================

Name: fadd_pipe

Overview:
Parametrised successor to the two-stage single-precision adder.
- Adds or subtracts two IEEE-754 binary32 operands through STAGES register stages, with a valid/ready handshake and backpressure.
- Carries a user tag through the pipeline and produces a real overflow flag.
- Sits between the FPU issue logic and the writeback arbiter. It replaces the free-running adder, which had no handshake.

Parameters:
STAGES, 2, pipeline depth in register stages; legal values 2 or 3 (3 adds a register after the add/normalise-shift-count step).
TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rstn  input  1  synchronous active-low reset.
in_valid  input  1  operands present.
in_ready  output  1  block accepts operands this cycle.
x1  input  32  operand A (binary32).
x2  input  32  operand B (binary32).
sub  input  1  0: A+B; 1: A-B (B sign inverted at entry).
in_tag  input  TAG_W  tag for this operation.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts result.
y  output  32  result (binary32).
ovf  output  1  result exponent overflowed; qualified by out_valid.
out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset: rstn sampled low at a clock edge clears every stage valid bit. out_valid=0, y=0, ovf=0, out_tag=0 from the next cycle. Any in-flight operations are discarded, including one mid-stall.
- Advance: adv = ~out_valid | out_ready, and in_ready = adv. When adv is high all stages shift together; when low all stages hold, including bubbles.
- Transfer: an operation is accepted when in_valid & in_ready.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no stall. Throughput is one operation per cycle.
- Output stability: while out_valid & ~out_ready, y, ovf and out_tag hold stable. Results leave in acceptance order.
- Denormal handling: an exponent field of 0 is treated as zero with effective exponent 1 (flush to zero).
- Operand ordering: the larger magnitude operand is chosen by exponent, then by mantissa on a tie. The smaller mantissa is right-shifted by the exponent difference, saturated at 31, with guard bits retained.
- Rounding: truncation (round toward zero).
- Normalisation: a carry-out increments the exponent and shifts right by 1. Otherwise leading-zero count and left shift. If the exponent would reach 0 or below, the result flushes to zero.
- Zero result: any zero mantissa result gives y=32'h00000000 (+0 always).
- Overflow: biased result exponent >= 255 gives y={sign,8'hFF,23'b0} and ovf=1. Otherwise ovf=0.
- Special inputs: without the optional feature, inputs with exponent 255 are treated as ordinary normals.
- Sign: the sign of the larger magnitude operand, after the sub inversion.

Optional Feature:
FADD_NAN_INF_EN.
- Defined:
  - Any NaN input gives the canonical NaN 32'h7FC00000.
  - inf + (-inf) gives 32'h7FC00000.
  - A single inf passes through with its sign.
  - ovf=0 for all NaN/inf inputs.
- Undefined: exponent 255 is handled arithmetically as above.
- Latency is unchanged in both cases.

Decomposition:
- Package fpu_pkg:
  - stage payload struct: sign, exponent, aligned mantissa, tag, special flags.
  - constants: EXP_MAX=255, MANT_W=23, GUARD_W=2.
- Sub-module fadd_norm: combinational leading-zero count, shift and exponent adjust. It is reused by fsub and fmul successors.

Test Plan:
- 3F800000+3F800000, sub=0, tag=5 -> y=40000000, ovf=0, out_tag=5, out_valid exactly STAGES cycles after acceptance.
- 3FC00000 with sub=1 and x2=3F000000 -> y=3F800000. The same x1 with x2=3FC00000, sub=1 -> y=00000000.
- 7F7FFFFF+7F7FFFFF -> y=7F800000, ovf=1.
- 00000001+3F800000 -> y=3F800000 (denormal flushed).
- Backpressure: in_valid held high with tags 0..7 and out_ready low for 3 cycles mid-stream:
  - in_ready goes low.
  - y and out_tag hold stable while stalled.
  - all 8 results arrive in order with no loss or duplication.
- Reset with 2 operations in flight -> out_valid=0 the cycle after rstn low and no stale result afterwards. With FADD_NAN_INF_EN, 7F800000+FF800000 -> 7FC00000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU constants and stage payload types for the binary32 add pipeline
// and its fsub/fmul siblings.
package fpu_pkg;
    localparam int              EXP_W     = 8;
    localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;            // 255
    localparam int              MANT_W    = 23;
    localparam int              GUARD_W   = 2;
    localparam int              SIG_W     = MANT_W + 1 + GUARD_W; // hidden + fraction + guard
    localparam int              SUM_W     = SIG_W + 1;            // plus carry-out
    localparam int              NEXP_W    = EXP_W + 2;            // room for +1 and negative
    localparam int              LZC_W     = 5;
    // Tags up to this width ride in the payload; wider TAG_W values are truncated.
    localparam int              TAG_MAX_W = 16;
    localparam logic [31:0]     QNAN      = 32'h7FC0_0000;

    // Aligned-and-summed operation, output of the entry stage.
    typedef struct packed {
        logic                 sign;
        logic [EXP_W-1:0]     exp;
        logic [SUM_W-1:0]     mant;
        logic                 nan;
        logic                 inf;
        logic [TAG_MAX_W-1:0] tag;
    } add_t;

    // Normalised operation, ready to be packed.
    typedef struct packed {
        logic                 sign;
        logic [NEXP_W-1:0]    exp;
        logic [MANT_W:0]      mant;
        logic                 zero;
        logic                 nan;
        logic                 inf;
        logic [TAG_MAX_W-1:0] tag;
    } norm_t;

    function automatic logic [31:0] inf_word(input logic s);
        return {s, EXP_MAX, {MANT_W{1'b0}}};
    endfunction
endpackage

// File: rtl/fadd_norm.sv
// Combinational normaliser: carry-out handling, leading-zero count, left
// shift and exponent adjust. Exponent out is two's complement NEXP_W bits.
module fadd_norm
    import fpu_pkg::*;
(
    input  logic [SUM_W-1:0]  mant_i,
    input  logic [EXP_W-1:0]  exp_i,
    output logic [MANT_W:0]   mant_o,
    output logic [NEXP_W-1:0] exp_o,
    output logic              zero_o
);
    logic [LZC_W-1:0] lzc;
    logic             found;
    logic [SIG_W-1:0] shifted;
    logic             unused_ok;

    // Leading-zero count over the significand below the carry bit.
    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!found && mant_i[i]) begin
                lzc   = LZC_W'(SIG_W - 1 - i);
                found = 1'b1;
            end
        end
    end

    assign shifted = mant_i[SIG_W-1:0] << lzc;

    // Carry-out shifts right by one; otherwise shift left by the zero count.
    // Guard bits are dropped here, which is the truncating rounding step.
    always_comb begin
        if (mant_i[SUM_W-1]) begin
            mant_o = mant_i[SUM_W-1:GUARD_W+1];
            exp_o  = {2'b00, exp_i} + NEXP_W'(1);
        end else begin
            mant_o = shifted[SIG_W-1:GUARD_W];
            exp_o  = {2'b00, exp_i} - {{(NEXP_W-LZC_W){1'b0}}, lzc};
        end
    end

    assign zero_o    = (mant_i == '0);
    assign unused_ok = ^shifted[GUARD_W-1:0];
endmodule

// File: rtl/fadd_pipe.sv
// Pipelined binary32 add/sub with valid/ready backpressure and a tag.
// STAGES = 2: entry(align+add) reg -> normalise/pack -> output reg.
// STAGES = 3: an extra register after the normalise step.
// Define FADD_NAN_INF_EN for IEEE NaN/inf handling; otherwise exponent 255
// is treated as an ordinary number.
module fadd_pipe
    import fpu_pkg::*;
#(
    parameter int STAGES = 2,   // 2 or 3
    parameter int TAG_W  = 4    // <= TAG_MAX_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);
    logic              adv;
    logic [STAGES-1:0] vld_q;
    add_t              add_d, add_q;
    norm_t             norm_d, norm_s;
    logic [31:0]       y_d, y_q;
    logic              ovf_d, ovf_q;
    logic [TAG_W-1:0]  tag_q;

    logic              sa, sb, a_big;
    logic [EXP_W-1:0]  ea, eb, e_big, e_sml, e_diff;
    logic [MANT_W:0]   ma, mb, m_big, m_sml;
    logic [4:0]        sh;
    logic [SIG_W-1:0]  big_al, sml_al;
    logic [MANT_W:0]   n_mant;
    logic [NEXP_W-1:0] n_exp;
    logic              n_zero;
    logic              unused_ok;
`ifdef FADD_NAN_INF_EN
    logic              a_nan, b_nan, a_inf, b_inf;
`endif

    // Whole pipe moves as one: any free output slot lets everything shift.
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];

    // Stage valid shift register; bubbles hold along with data on a stall.
    always_ff @(posedge clk) begin
        if (!rstn)    vld_q <= '0;
        else if (adv) vld_q <= {vld_q[STAGES-2:0], in_valid};
    end

    // Entry: flush denormals, order by magnitude, align and add/subtract.
    always_comb begin
        add_d  = '0;
        sa     = x1[31];
        sb     = x2[31] ^ sub;
        ea     = (x1[30:23] == '0) ? 8'd1 : x1[30:23];
        eb     = (x2[30:23] == '0) ? 8'd1 : x2[30:23];
        ma     = (x1[30:23] == '0) ? '0 : {1'b1, x1[22:0]};
        mb     = (x2[30:23] == '0) ? '0 : {1'b1, x2[22:0]};
        a_big  = (ea > eb) || ((ea == eb) && (ma >= mb));
        e_big  = a_big ? ea : eb;
        e_sml  = a_big ? eb : ea;
        m_big  = a_big ? ma : mb;
        m_sml  = a_big ? mb : ma;
        e_diff = e_big - e_sml;
        sh     = (e_diff > 8'd31) ? 5'd31 : e_diff[4:0];
        big_al = {m_big, {GUARD_W{1'b0}}};
        sml_al = {m_sml, {GUARD_W{1'b0}}} >> sh;
        add_d.sign = a_big ? sa : sb;
        add_d.exp  = e_big;
        add_d.mant = (sa ^ sb) ? ({1'b0, big_al} - {1'b0, sml_al})
                               : ({1'b0, big_al} + {1'b0, sml_al});
        add_d.tag  = TAG_MAX_W'(in_tag);
`ifdef FADD_NAN_INF_EN
        a_nan = (x1[30:23] == EXP_MAX) && (x1[22:0] != '0);
        b_nan = (x2[30:23] == EXP_MAX) && (x2[22:0] != '0);
        a_inf = (x1[30:23] == EXP_MAX) && (x1[22:0] == '0);
        b_inf = (x2[30:23] == EXP_MAX) && (x2[22:0] == '0);
        add_d.nan = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
        add_d.inf = (a_inf | b_inf) & ~add_d.nan;
        if (add_d.inf) add_d.sign = a_inf ? sa : sb;
`else
        add_d.nan = 1'b0;
        add_d.inf = 1'b0;
`endif
    end

    // Entry stage register.
    always_ff @(posedge clk) begin
        if (!rstn)    add_q <= '0;
        else if (adv) add_q <= add_d;
    end

    fadd_norm u_norm (
        .mant_i (add_q.mant),
        .exp_i  (add_q.exp),
        .mant_o (n_mant),
        .exp_o  (n_exp),
        .zero_o (n_zero)
    );

    // Gather the normalised result with the fields that ride alongside.
    always_comb begin
        norm_d      = '0;
        norm_d.sign = add_q.sign;
        norm_d.exp  = n_exp;
        norm_d.mant = n_mant;
        norm_d.zero = n_zero;
        norm_d.nan  = add_q.nan;
        norm_d.inf  = add_q.inf;
        norm_d.tag  = add_q.tag;
    end

    generate
        if (STAGES == 3) begin : g_mid
            norm_t norm_q;
            // Optional register between normalise and pack.
            always_ff @(posedge clk) begin
                if (!rstn)    norm_q <= '0;
                else if (adv) norm_q <= norm_d;
            end
            assign norm_s = norm_q;
        end else begin : g_nomid
            assign norm_s = norm_d;
        end
    endgenerate

    // Pack: specials first, then underflow flush, overflow, normal.
    always_comb begin
        y_d   = '0;
        ovf_d = 1'b0;
        if (norm_s.nan) begin
            y_d = QNAN;
        end else if (norm_s.inf) begin
            y_d = inf_word(norm_s.sign);
        end else if (norm_s.zero || norm_s.exp[NEXP_W-1] || (norm_s.exp == '0)) begin
            y_d = '0;
        end else if (norm_s.exp >= {2'b00, EXP_MAX}) begin
            y_d   = inf_word(norm_s.sign);
            ovf_d = 1'b1;
        end else begin
            y_d = {norm_s.sign, norm_s.exp[EXP_W-1:0], norm_s.mant[MANT_W-1:0]};
        end
    end

    // Output register; bubbles load zeros so an idle output reads clean.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            y_q   <= '0;
            ovf_q <= 1'b0;
            tag_q <= '0;
        end else if (adv) begin
            if (vld_q[STAGES-2]) begin
                y_q   <= y_d;
                ovf_q <= ovf_d;
                tag_q <= norm_s.tag[TAG_W-1:0];
            end else begin
                y_q   <= '0;
                ovf_q <= 1'b0;
                tag_q <= '0;
            end
        end
    end

    assign y         = y_q;
    assign ovf       = ovf_q;
    assign out_tag   = tag_q;
    assign unused_ok = ^{norm_s.mant[MANT_W], norm_s.tag};
endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe: single ops with latency, backpressure
// ordering/stability, reset while stalled, and exponent-255 handling.
module tb_fadd_pipe;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid, in_ready;
    logic [31:0]      x1, x2;
    logic             sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready;
    logic [31:0]      y;
    logic             ovf;
    logic [TAG_W-1:0] out_tag;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    fadd_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .sub(sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h want %h", nm, obs, exp);
        end
    endtask

    // One isolated operation; checks latency, result, overflow and tag.
    task automatic op(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [TAG_W-1:0] t,
                      input logic [31:0] ey, input logic eovf);
        int n;
        x1 = a; x2 = b; sub = s; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        n = 0;
        tick(); n++;
        in_valid = 1'b0;
        while (!out_valid && n < 20) begin
            tick(); n++;
        end
        check({nm, ".latency"}, 32'(n), 32'(STAGES));
        check({nm, ".y"}, y, ey);
        check({nm, ".ovf"}, 32'(ovf), 32'(eovf));
        check({nm, ".tag"}, 32'(out_tag), 32'(t));
        tick();
    endtask

    initial begin
        logic [31:0]      held_y;
        logic [TAG_W-1:0] held_tag;
        logic             prev_stall, saw_stall, acc, outx, stale;
        int               sent, got;

        rstn = 1'b0; in_valid = 1'b0; x1 = '0; x2 = '0; sub = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        repeat (3) tick();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.y", y, 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        check("rst.tag", 32'(out_tag), 32'd0);
        rstn = 1'b1;
        tick();

        op("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 4'd5, 32'h40000000, 1'b0);
        op("1.5_minus_0.5", 32'h3FC00000, 32'h3F000000, 1'b1, 4'd1, 32'h3F800000, 1'b0);
        op("x_minus_x",     32'h3FC00000, 32'h3FC00000, 1'b1, 4'd2, 32'h00000000, 1'b0);
        op("3_minus_1",     32'h40400000, 32'h3F800000, 1'b1, 4'd3, 32'h40000000, 1'b0);
        op("1_minus_2",     32'h3F800000, 32'h40000000, 1'b1, 4'd4, 32'hBF800000, 1'b0);
        op("max_plus_max",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd6, 32'h7F800000, 1'b1);
        op("nmax_plus_nmax",32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 4'd7, 32'hFF800000, 1'b1);
        op("denorm_flush",  32'h00000001, 32'h3F800000, 1'b0, 4'd8, 32'h3F800000, 1'b0);
        op("underflow",     32'h00C00000, 32'h00800000, 1'b1, 4'd9, 32'h00000000, 1'b0);
`ifdef FADD_NAN_INF_EN
        op("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 4'd10, 32'h7F800000, 1'b0);
        op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 4'd11, 32'h7FC00000, 1'b0);
        op("nan_in",        32'h7FC00001, 32'h3F800000, 1'b0, 4'd12, 32'h7FC00000, 1'b0);
`else
        op("e255_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 4'd10, 32'h7F800000, 1'b1);
        op("e255_cancel",   32'h7F800000, 32'hFF800000, 1'b0, 4'd11, 32'h00000000, 1'b0);
`endif

        // Backpressure: 8 back-to-back ops (x + 0 = x), consumer stalls cycles 3..5.
        sent = 0; got = 0; prev_stall = 1'b0; saw_stall = 1'b0;
        held_y = '0; held_tag = '0;
        sub = 1'b0; x2 = 32'h0; in_valid = 1'b1;
        x1 = 32'h40000000 | (32'(sent) << 16); in_tag = TAG_W'(sent);
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            #1;
            if (out_valid && !out_ready) begin
                saw_stall = 1'b1;
                check("bp.in_ready_low", 32'(in_ready), 32'd0);
                if (prev_stall) begin
                    check("bp.y_hold", y, held_y);
                    check("bp.tag_hold", 32'(out_tag), 32'(held_tag));
                end
            end
            if (out_valid) begin
                check("bp.y", y, 32'h40000000 | (32'(got) << 16));
                check("bp.tag", 32'(out_tag), 32'(got));
                held_y = y; held_tag = out_tag;
            end
            prev_stall = out_valid && !out_ready;
            acc  = in_valid && in_ready;
            outx = out_valid && out_ready;
            tick();
            if (acc) begin
                sent++;
                if (sent < 8) begin
                    x1 = 32'h40000000 | (32'(sent) << 16); in_tag = TAG_W'(sent);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (outx) got++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp.sent", 32'(sent), 32'd8);
        check("bp.got", 32'(got), 32'd8);
        check("bp.stalled", 32'(saw_stall), 32'd1);
        stale = 1'b0;
        repeat (4) begin tick(); if (out_valid) stale = 1'b1; end
        check("bp.no_dup", 32'(stale), 32'd0);

        // Reset with two ops in flight, the first stalled at the output.
        out_ready = 1'b0; in_valid = 1'b1;
        x1 = 32'h7F7FFFFF; x2 = 32'h7F7FFFFF; in_tag = 4'hA; tick();
        x1 = 32'h3F800000; x2 = 32'h3F800000; in_tag = 4'hB; tick();
        in_valid = 1'b0; tick();
        check("rst2.pre_valid", 32'(out_valid), 32'd1);
        check("rst2.pre_ovf", 32'(ovf), 32'd1);
        rstn = 1'b0; tick();
        check("rst2.out_valid", 32'(out_valid), 32'd0);
        check("rst2.y", y, 32'd0);
        check("rst2.ovf", 32'(ovf), 32'd0);
        check("rst2.tag", 32'(out_tag), 32'd0);
        rstn = 1'b1; out_ready = 1'b1;
        stale = 1'b0;
        repeat (5) begin tick(); if (out_valid) stale = 1'b1; end
        check("rst2.no_stale", 32'(stale), 32'd0);

        op("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 4'd15, 32'h40000000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
